// File: rtl/pe_pool_enc_pkg.sv
// pe_pool_enc_pkg
// Shared definitions for the pooling encoder. The unpooling demux and the
// combinational PE import the same helpers, so the pindex encoding and the
// batch-norm reference stay bit-identical across the datapath.
//   pindex_width() : index width for an n-entry window, never below 1
//   n_pool()       : samples per pooling window
//   bn_ref()       : batch-norm threshold for a popcount sum
//   state_t/dbg_t  : FSM state encoding and the debug view of the FSM
package pe_pool_enc_pkg;

    function automatic int pindex_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int n_pool(input int pool_h, input int pool_w);
        return pool_h * pool_w;
    endfunction

    // Both halves are divided separately so each truncates toward zero;
    // dividing the sum instead would round odd negative norm_ref differently.
    function automatic logic signed [31:0] bn_ref(input int fh, input int fw, input int d,
                                                  input logic signed [31:0] norm_ref);
        logic signed [31:0] base;
        base = fh * fw * d;
        return (base / 2) + (norm_ref / 2);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam int DBG_CNT_W = 8;

    typedef struct packed {
        state_t               state;
        logic [DBG_CNT_W-1:0] cnt;
    } dbg_t;

endpackage

// File: rtl/pe_pool_enc_pool_argsel.sv
// pool_argsel
// Combinational selection step of the pooling encoder.
//   cand     : incoming conv sum
//   best     : best conv sum held so far in the window
//   s        : BN scale sign (0: track maximum, 1: track minimum)
//   pool_val : value that will be emitted for the window
//   ref_val  : signed batch-norm reference, one bit wider than the sums
//   replace  : cand strictly beats best (ties keep the earlier sample)
//   bin      : binarized bit of pool_val against ref_val
module pool_argsel
    import pe_pool_enc_pkg::*;
#(
    parameter int W = 13
) (
    input  logic [W-1:0]        cand,
    input  logic [W-1:0]        best,
    input  logic                s,
    input  logic [W-1:0]        pool_val,
    input  logic signed [W:0]   ref_val,
    output logic                replace,
    output logic                bin
);

    logic signed [W:0] pool_ext;

    always_comb begin
        // Sums are unsigned popcounts; the leading zero keeps them positive
        // in the signed compare against a possibly negative reference.
        pool_ext = $signed({1'b0, pool_val});
        if (s) begin
            replace = (cand < best);
            bin     = (pool_ext <= ref_val);
        end else begin
            replace = (cand > best);
            bin     = (pool_ext >= ref_val);
        end
    end

endmodule

// File: rtl/pe_pool_enc.sv
// pe_pool_enc
// Streaming pooling encoder: collects POOL_H*POOL_W popcount sums per window
// in raster order, keeps the extremum selected by s, and emits its value,
// raster index and binarized bit.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous abort of the partial window
//   in_valid/in_ready   : sample handshake (conv_in, norm_ref, s)
//   out_valid/out_ready : result handshake (pool_val, pindex, bin_out)
//   dbg                 : FSM state and sample counter
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. out_valid and its payload stay stable until taken. in_ready is
// high unless a result is pending and not being taken this cycle, so a new
// result can replace the one leaving in the same cycle.
module pe_pool_enc
    import pe_pool_enc_pkg::*;
#(
    parameter int D             = 512,
    parameter int FH            = 3,
    parameter int FW            = 3,
    parameter int POOL_H        = 2,
    parameter int POOL_W        = 2,
    parameter int NORMREF_WIDTH = 13,
    localparam int N_POOL       = n_pool(POOL_H, POOL_W),
    localparam int PINDEX_WIDTH = pindex_width(N_POOL)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NORMREF_WIDTH-1:0] conv_in,
    input  logic [NORMREF_WIDTH-1:0] norm_ref,
    input  logic                     s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NORMREF_WIDTH-1:0] pool_val,
    output logic [PINDEX_WIDTH-1:0]  pindex,
    output logic                     bin_out,
    output dbg_t                     dbg
);

    localparam int W  = NORMREF_WIDTH;
    localparam int PW = PINDEX_WIDTH;

    state_t          state;
    logic [PW-1:0]   cnt;
    logic [W-1:0]    best_val;
    logic [PW-1:0]   best_idx;
    logic            s_lat;
    logic [W-1:0]    nref_lat;

    logic            idle;
    logic            accept;
    logic            last;
    logic            cur_s;
    logic [W-1:0]    cur_nref;
    logic [W-1:0]    sel_val;
    logic [PW-1:0]   sel_idx;
    logic            replace;
    logic            bin_sel;
    logic signed [W:0] ref_val;

    assign in_ready = !out_valid || out_ready;

    // In IDLE the window's s and norm_ref are still on the inputs; they are
    // used directly so a single-sample window binarizes correctly.
    always_comb begin
        idle     = (state == ST_IDLE);
        accept   = in_valid && in_ready;
        cur_s    = idle ? s : s_lat;
        cur_nref = idle ? norm_ref : nref_lat;
        last     = idle ? (N_POOL == 1) : (cnt == PW'(N_POOL - 1));
        if (idle || replace) begin
            sel_val = conv_in;
            sel_idx = cnt;
        end else begin
            sel_val = best_val;
            sel_idx = best_idx;
        end
    end

    assign ref_val = (W + 1)'(bn_ref(FH, FW, D, 32'(signed'(cur_nref))));

    pool_argsel #(.W(W)) u_argsel (
        .cand     (conv_in),
        .best     (best_val),
        .s        (cur_s),
        .pool_val (sel_val),
        .ref_val  (ref_val),
        .replace  (replace),
        .bin      (bin_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            s_lat     <= 1'b0;
            nref_lat  <= '0;
            out_valid <= 1'b0;
            pool_val  <= '0;
            pindex    <= '0;
            bin_out   <= 1'b0;
        end else begin
            // clear wins over a concurrent accept: that sample is dropped.
            if (clear) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (accept) begin
                best_val <= sel_val;
                best_idx <= sel_idx;
                if (idle) begin
                    s_lat    <= s;
                    nref_lat <= norm_ref;
                end
                if (last) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= ST_ACC;
                    cnt   <= cnt + PW'(1);
                end
            end

            if (!clear && accept && last) begin
                out_valid <= 1'b1;
                pool_val  <= sel_val;
                pindex    <= sel_idx;
                bin_out   <= bin_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        dbg.state = state;
        dbg.cnt   = DBG_CNT_W'(cnt);
    end

endmodule

// File: tb/tb_pe_pool_enc.sv
// tb_pe_pool_enc
// Directed bench for pe_pool_enc at default parameters (2x2 window,
// reference 2304 for norm_ref=0). Inputs change 1 ns after the rising edge
// and outputs are sampled there as well.
module tb_pe_pool_enc;
    import pe_pool_enc_pkg::*;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] conv_in = '0;
    logic [W-1:0] norm_ref = '0;
    logic         s = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] pool_val;
    logic [1:0]   pindex;
    logic         bin_out;
    dbg_t         dbg;

    int errors = 0;
    int checks = 0;

    pe_pool_enc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .conv_in   (conv_in),
        .norm_ref  (norm_ref),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pool_val  (pool_val),
        .pindex    (pindex),
        .bin_out   (bin_out),
        .dbg       (dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v);
        in_valid = 1'b1;
        conv_in  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int val, input int idx, input logic bin);
        check({tag, ".out_valid"}, out_valid, 1);
        check({tag, ".pool_val"}, pool_val, val);
        check({tag, ".pindex"}, pindex, idx);
        check({tag, ".bin_out"}, bin_out, bin);
    endtask

    initial begin
        logic [W-1:0] b2b [8];
        b2b = '{13'd1, 13'd2, 13'd3, 13'd4, 13'd3000, 13'd3000, 13'd100, 13'd2400};

        // Reset state
        tick();
        tick();
        check("rst.out_valid", out_valid, 0);
        check("rst.pool_val", pool_val, 0);
        check("rst.pindex", pindex, 0);
        check("rst.bin_out", bin_out, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.state", dbg.state, ST_IDLE);
        rst_n = 1'b1;
        tick();

        // Max tracking, ref 2304
        s = 1'b0;
        norm_ref = '0;
        send(13'd100);
        send(13'd3000);
        send(13'd2500);
        check("w1.early_valid", out_valid, 0);
        send(13'd2999);
        check_result("w1", 3000, 1, 1'b1);

        // Min tracking with tie, ref 2204
        s = 1'b1;
        norm_ref = 13'(-200);
        send(13'd2500);
        check("w2.consumed", out_valid, 0);
        send(13'd2300);
        send(13'd2300);
        send(13'd2400);
        check_result("w2", 2300, 1, 1'b0);

        // Back-to-back windows with out_ready held high
        s = 1'b0;
        norm_ref = '0;
        for (int i = 0; i < 8; i++) begin
            check("b2b.in_ready", in_ready, 1);
            send(b2b[i]);
            check("b2b.out_valid", out_valid, (i == 3 || i == 7) ? 1 : 0);
            if (i == 3) check_result("w3", 4, 3, 1'b0);
        end
        check_result("w4", 3000, 0, 1'b1);

        // Backpressure: result held, input stalled
        out_ready = 1'b0;
        #1;
        check("stall.in_ready", in_ready, 0);
        in_valid = 1'b1;
        conv_in  = 13'd7000;
        tick();
        tick();
        check("stall.in_ready2", in_ready, 0);
        check("stall.cnt", dbg.cnt, 0);
        check_result("stall", 3000, 0, 1'b1);
        out_ready = 1'b1;
        #1;
        check("release.in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("release.out_valid", out_valid, 0);
        check("release.cnt", dbg.cnt, 1);
        send(13'd10);
        send(13'd20);
        send(13'd7001);
        check_result("w5", 7001, 3, 1'b1);

        // clear drops the partial window and a concurrent sample
        send(13'd50);
        send(13'd60);
        clear    = 1'b1;
        in_valid = 1'b1;
        conv_in  = 13'd8000;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear.cnt", dbg.cnt, 0);
        check("clear.state", dbg.state, ST_IDLE);
        send(13'd10);
        send(13'd20);
        send(13'd30);
        check("clear.early_valid", out_valid, 0);
        send(13'd5);
        check_result("w6", 30, 2, 1'b0);

        // clear leaves a pending result alone
        out_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_result("clear_hold", 30, 2, 1'b0);

        // Async reset with a result pending
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", out_valid, 0);
        check("arst.pool_val", pool_val, 0);
        check("arst.pindex", pindex, 0);
        check("arst.bin_out", bin_out, 0);
        check("arst.in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Async reset mid-window loses the partial samples
        s = 1'b0;
        send(13'd6000);
        send(13'd6001);
        check("part.out_valid", out_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check("part.cnt", dbg.cnt, 0);
        tick();
        rst_n = 1'b1;

        // Fresh window after reset; odd negative norm_ref truncates to -100
        s = 1'b1;
        norm_ref = 13'(-201);
        send(13'd2300);
        send(13'd2204);
        send(13'd2250);
        check("w7.early_valid", out_valid, 0);
        send(13'd2210);
        check_result("w7", 2204, 1, 1'b1);
        tick();
        check("w7.drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
